timer_apb_arb: RTL and testbench

TIMER_APB_ARB -- requirements
Module: timer_apb_arb

---
 rtl/timer_apb_arb_pkg.sv | 24 ++
 rtl/timer_apb_arb_rr.sv | 22 ++
 rtl/timer_apb_arb.sv | 199 +++++++++++++++++++
 tb/tb_timer_apb_arb.sv | 258 +++++++++++++++++++++++++
 4 files changed

// File: rtl/timer_apb_arb_pkg.sv
// Shared types and constants for the two-requester APB arbiter in front of the timer.
package timer_apb_arb_pkg;

  localparam int ADDR_W          = 12;
  localparam int DATA_W          = 32;
  localparam int STRB_W          = 4;
  localparam int TIMEOUT_CYC_DEF = 16;
  // Wide enough for the largest legal TIMEOUT_CYC (255).
  localparam int CNT_W           = 8;

  typedef enum logic [1:0] {
    ST_IDLE   = 2'd0,
    ST_SETUP  = 2'd1,
    ST_ACCESS = 2'd2,
    ST_RESP   = 2'd3
  } arb_state_t;

  // Byte strobes are meaningless on reads, so they never reach the timer.
  function automatic logic [STRB_W-1:0] strb_for(input logic               pwrite,
                                                 input logic [STRB_W-1:0]  strb);
    return pwrite ? strb : '0;
  endfunction

endpackage

// File: rtl/timer_apb_arb_rr.sv
// Two-way round-robin picker: one-hot grant from the request pair and a pointer.
// ptr = 0 favours requester 0 on a collision, ptr = 1 favours requester 1.
module timer_apb_arb_rr
  import timer_apb_arb_pkg::*;
(
  input  logic [1:0] req,
  input  logic       ptr,
  output logic [1:0] gnt
);

  // Single requester wins outright; on a collision the pointer decides.
  always_comb begin
    gnt = 2'b00;
    case (req)
      2'b01:   gnt = 2'b01;
      2'b10:   gnt = 2'b10;
      2'b11:   gnt = ptr ? 2'b10 : 2'b01;
      default: gnt = 2'b00;
    endcase
  end

endmodule

// File: rtl/timer_apb_arb.sv
// Arbitrates two APB requesters onto the single APB port of the timer.
// One transfer at a time: IDLE -> SETUP -> ACCESS -> RESP -> IDLE, with an
// ACCESS-phase timeout that aborts a hung timer and reports a slave error.
module timer_apb_arb
  import timer_apb_arb_pkg::*;
#(
  parameter int TIMEOUT_CYC = TIMEOUT_CYC_DEF
) (
  input  logic              sys_clk,
  input  logic              sys_rst_n,

  input  logic              m0_psel,
  input  logic              m0_penable,
  input  logic              m0_pwrite,
  input  logic [ADDR_W-1:0] m0_paddr,
  input  logic [DATA_W-1:0] m0_pwdata,
  input  logic [STRB_W-1:0] m0_pstrb,
  output logic [DATA_W-1:0] m0_prdata,
  output logic              m0_pready,
  output logic              m0_pslverr,

  input  logic              m1_psel,
  input  logic              m1_penable,
  input  logic              m1_pwrite,
  input  logic [ADDR_W-1:0] m1_paddr,
  input  logic [DATA_W-1:0] m1_pwdata,
  input  logic [STRB_W-1:0] m1_pstrb,
  output logic [DATA_W-1:0] m1_prdata,
  output logic              m1_pready,
  output logic              m1_pslverr,

  output logic              tim_psel,
  output logic              tim_penable,
  output logic              tim_pwrite,
  output logic [ADDR_W-1:0] tim_paddr,
  output logic [DATA_W-1:0] tim_pwdata,
  output logic [STRB_W-1:0] tim_pstrb,
  input  logic [DATA_W-1:0] tim_prdata,
  input  logic              tim_pready,
  input  logic              tim_pslverr,

  output logic [1:0]        arb_gnt,
  output logic              arb_timeout
);

  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(TIMEOUT_CYC - 1);

  arb_state_t        state_q, state_d;
  logic [1:0]        gnt_q;
  logic              ptr_q;
  logic              pwrite_q;
  logic [ADDR_W-1:0] paddr_q;
  logic [DATA_W-1:0] pwdata_q;
  logic [STRB_W-1:0] pstrb_q;
  logic [CNT_W-1:0]  cnt_q;
  logic [DATA_W-1:0] rdata_q;
  logic              slverr_q;
  logic              to_q;

  logic [1:0]        req;
  logic [1:0]        pick_gnt;
  logic              start;
  logic              access_done;
  logic              access_abort;
  logic              resp0_ok;
  logic              resp1_ok;

  assign req          = {m1_psel, m0_psel};
  assign start        = (state_q == ST_IDLE) && (req != 2'b00);
  assign access_done  = (state_q == ST_ACCESS) && tim_pready;
  assign access_abort = (state_q == ST_ACCESS) && !tim_pready && (cnt_q == CNT_LAST);

  // A response is only handed back if the owner is still in its access phase;
  // a requester that walked away simply never sees pready.
  assign resp0_ok = (state_q == ST_RESP) && gnt_q[0] && m0_psel && m0_penable;
  assign resp1_ok = (state_q == ST_RESP) && gnt_q[1] && m1_psel && m1_penable;

  timer_apb_arb_rr u_rr (
    .req (req),
    .ptr (ptr_q),
    .gnt (pick_gnt)
  );

  // State register.
  always_ff @(posedge sys_clk or negedge sys_rst_n) begin
    if (!sys_rst_n) state_q <= ST_IDLE;
    else            state_q <= state_d;
  end

  // Next-state logic and all port outputs, decoded from the current state.
  always_comb begin
    state_d     = state_q;
    tim_psel    = 1'b0;
    tim_penable = 1'b0;
    tim_pwrite  = 1'b0;
    tim_paddr   = '0;
    tim_pwdata  = '0;
    tim_pstrb   = '0;
    m0_pready   = 1'b0;
    m0_prdata   = '0;
    m0_pslverr  = 1'b0;
    m1_pready   = 1'b0;
    m1_prdata   = '0;
    m1_pslverr  = 1'b0;
    case (state_q)
      ST_IDLE: begin
        if (start) state_d = ST_SETUP;
      end
      ST_SETUP: begin
        tim_psel   = 1'b1;
        tim_pwrite = pwrite_q;
        tim_paddr  = paddr_q;
        tim_pwdata = pwdata_q;
        tim_pstrb  = strb_for(pwrite_q, pstrb_q);
        state_d    = ST_ACCESS;
      end
      ST_ACCESS: begin
        tim_psel    = 1'b1;
        tim_penable = 1'b1;
        tim_pwrite  = pwrite_q;
        tim_paddr   = paddr_q;
        tim_pwdata  = pwdata_q;
        tim_pstrb   = strb_for(pwrite_q, pstrb_q);
        if (access_done || access_abort) state_d = ST_RESP;
      end
      ST_RESP: begin
        m0_pready  = resp0_ok;
        m0_prdata  = resp0_ok ? rdata_q : '0;
        m0_pslverr = resp0_ok && slverr_q;
        m1_pready  = resp1_ok;
        m1_prdata  = resp1_ok ? rdata_q : '0;
        m1_pslverr = resp1_ok && slverr_q;
        state_d    = ST_IDLE;
      end
      default: state_d = ST_IDLE;
    endcase
  end

  // Ownership and fairness: grant is held for the whole transfer; when it
  // ends (completed, aborted or abandoned) the pointer favours the other side.
  always_ff @(posedge sys_clk or negedge sys_rst_n) begin
    if (!sys_rst_n) begin
      gnt_q <= 2'b00;
      ptr_q <= 1'b0;
    end else if (start) begin
      gnt_q <= pick_gnt;
    end else if (state_q == ST_RESP) begin
      gnt_q <= 2'b00;
      ptr_q <= gnt_q[0];
    end
  end

  // Capture the winner's command fields when the transfer is granted.
  always_ff @(posedge sys_clk or negedge sys_rst_n) begin
    if (!sys_rst_n) begin
      pwrite_q <= 1'b0;
      paddr_q  <= '0;
      pwdata_q <= '0;
      pstrb_q  <= '0;
    end else if (start) begin
      pwrite_q <= pick_gnt[1] ? m1_pwrite : m0_pwrite;
      paddr_q  <= pick_gnt[1] ? m1_paddr  : m0_paddr;
      pwdata_q <= pick_gnt[1] ? m1_pwdata : m0_pwdata;
      pstrb_q  <= pick_gnt[1] ? strb_for(m1_pwrite, m1_pstrb)
                              : strb_for(m0_pwrite, m0_pstrb);
    end
  end

  // ACCESS wait-state counter: cleared in SETUP, counts cycles without pready.
  always_ff @(posedge sys_clk or negedge sys_rst_n) begin
    if (!sys_rst_n)                             cnt_q <= '0;
    else if (state_q == ST_SETUP)               cnt_q <= '0;
    else if (state_q == ST_ACCESS && !tim_pready) cnt_q <= cnt_q + 1'b1;
  end

  // Response capture: timer data on completion, forced error on abort.
  always_ff @(posedge sys_clk or negedge sys_rst_n) begin
    if (!sys_rst_n) begin
      rdata_q  <= '0;
      slverr_q <= 1'b0;
    end else if (access_done) begin
      rdata_q  <= pwrite_q ? '0 : tim_prdata;
      slverr_q <= tim_pslverr;
    end else if (access_abort) begin
      rdata_q  <= '0;
      slverr_q <= 1'b1;
    end
  end

  // Timeout flag lands in the single RESP cycle that follows an abort.
  always_ff @(posedge sys_clk or negedge sys_rst_n) begin
    if (!sys_rst_n) to_q <= 1'b0;
    else            to_q <= access_abort;
  end

  assign arb_gnt     = gnt_q;
  assign arb_timeout = to_q;

endmodule

// File: tb/tb_timer_apb_arb.sv
// Directed bench for timer_apb_arb: arbitration order, timer phases,
// timeout abort, slave error, async reset and abandoned transfers.
module tb_timer_apb_arb;

  logic        sys_clk = 1'b0;
  logic        sys_rst_n;
  logic        m0_psel, m0_penable, m0_pwrite;
  logic [11:0] m0_paddr;
  logic [31:0] m0_pwdata;
  logic [3:0]  m0_pstrb;
  logic [31:0] m0_prdata;
  logic        m0_pready, m0_pslverr;
  logic        m1_psel, m1_penable, m1_pwrite;
  logic [11:0] m1_paddr;
  logic [31:0] m1_pwdata;
  logic [3:0]  m1_pstrb;
  logic [31:0] m1_prdata;
  logic        m1_pready, m1_pslverr;
  logic        tim_psel, tim_penable, tim_pwrite;
  logic [11:0] tim_paddr;
  logic [31:0] tim_pwdata;
  logic [3:0]  tim_pstrb;
  logic [31:0] tim_prdata;
  logic        tim_pready, tim_pslverr;
  logic [1:0]  arb_gnt;
  logic        arb_timeout;

  int checks = 0;
  int errors = 0;

  always #5 sys_clk = ~sys_clk;

  timer_apb_arb #(.TIMEOUT_CYC(16)) dut (
    .sys_clk(sys_clk), .sys_rst_n(sys_rst_n),
    .m0_psel(m0_psel), .m0_penable(m0_penable), .m0_pwrite(m0_pwrite),
    .m0_paddr(m0_paddr), .m0_pwdata(m0_pwdata), .m0_pstrb(m0_pstrb),
    .m0_prdata(m0_prdata), .m0_pready(m0_pready), .m0_pslverr(m0_pslverr),
    .m1_psel(m1_psel), .m1_penable(m1_penable), .m1_pwrite(m1_pwrite),
    .m1_paddr(m1_paddr), .m1_pwdata(m1_pwdata), .m1_pstrb(m1_pstrb),
    .m1_prdata(m1_prdata), .m1_pready(m1_pready), .m1_pslverr(m1_pslverr),
    .tim_psel(tim_psel), .tim_penable(tim_penable), .tim_pwrite(tim_pwrite),
    .tim_paddr(tim_paddr), .tim_pwdata(tim_pwdata), .tim_pstrb(tim_pstrb),
    .tim_prdata(tim_prdata), .tim_pready(tim_pready), .tim_pslverr(tim_pslverr),
    .arb_gnt(arb_gnt), .arb_timeout(arb_timeout)
  );

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  // Advance to just after the next rising edge.
  task automatic step();
    @(posedge sys_clk);
    #1;
  endtask

  task automatic drv_m0(input logic sel, input logic en, input logic wr,
                        input logic [11:0] a, input logic [31:0] d, input logic [3:0] s);
    m0_psel = sel; m0_penable = en; m0_pwrite = wr;
    m0_paddr = a; m0_pwdata = d; m0_pstrb = s;
  endtask

  task automatic drv_m1(input logic sel, input logic en, input logic wr,
                        input logic [11:0] a, input logic [31:0] d, input logic [3:0] s);
    m1_psel = sel; m1_penable = en; m1_pwrite = wr;
    m1_paddr = a; m1_pwdata = d; m1_pstrb = s;
  endtask

  initial begin
    sys_rst_n = 1'b0;
    drv_m0(0, 0, 0, 12'h0, 32'h0, 4'h0);
    drv_m1(0, 0, 0, 12'h0, 32'h0, 4'h0);
    tim_prdata = 32'h0; tim_pready = 1'b0; tim_pslverr = 1'b0;

    // Reset state
    #3;
    chk("rst_tim_psel", 32'(tim_psel), 32'd0);
    chk("rst_gnt", 32'(arb_gnt), 32'd0);
    chk("rst_m0_pready", 32'(m0_pready), 32'd0);
    chk("rst_timeout", 32'(arb_timeout), 32'd0);
    repeat (2) @(posedge sys_clk);
    @(negedge sys_clk);
    sys_rst_n = 1'b1;

    // Collision right after reset: m0 read 0x000 wins, m1 read 0x008 waits
    drv_m0(1, 0, 0, 12'h000, 32'h0, 4'hF);
    drv_m1(1, 0, 0, 12'h008, 32'h0, 4'hF);
    step();
    chk("c1_setup_gnt", 32'(arb_gnt), 32'h1);
    chk("c1_setup_psel", 32'(tim_psel), 32'd1);
    chk("c1_setup_pen", 32'(tim_penable), 32'd0);
    chk("c1_setup_addr", 32'(tim_paddr), 32'h000);
    chk("c1_read_strb0", 32'(tim_pstrb), 32'h0);
    m0_penable = 1'b1; m1_penable = 1'b1;
    tim_pready = 1'b1; tim_prdata = 32'h1111_1111;
    step();
    chk("c1_access_pen", 32'(tim_penable), 32'd1);
    chk("c1_access_m0_rdy", 32'(m0_pready), 32'd0);
    step();
    chk("c1_resp_m0_rdy", 32'(m0_pready), 32'd1);
    chk("c1_resp_m0_data", m0_prdata, 32'h1111_1111);
    chk("c1_resp_m0_err", 32'(m0_pslverr), 32'd0);
    chk("c1_m1_waits", 32'(m1_pready), 32'd0);
    chk("c1_m1_data0", m1_prdata, 32'h0);
    chk("c1_resp_tim_psel", 32'(tim_psel), 32'd0);
    drv_m0(0, 0, 0, 12'h0, 32'h0, 4'h0);
    tim_prdata = 32'h2222_2222;
    step();
    chk("c1_idle_gnt", 32'(arb_gnt), 32'h0);
    step();
    chk("c2_setup_gnt", 32'(arb_gnt), 32'h2);
    chk("c2_setup_addr", 32'(tim_paddr), 32'h008);
    step();
    step();
    chk("c2_resp_m1_rdy", 32'(m1_pready), 32'd1);
    chk("c2_resp_m1_data", m1_prdata, 32'h2222_2222);
    chk("c2_resp_m0_rdy", 32'(m0_pready), 32'd0);
    drv_m1(0, 0, 0, 12'h0, 32'h0, 4'h0);
    tim_pready = 1'b0; tim_prdata = 32'h0;
    step();

    // m0 write 0xFF to 0x004, m1 idle
    drv_m0(1, 0, 1, 12'h004, 32'h0000_00FF, 4'hF);
    tim_pready = 1'b1; tim_prdata = 32'hAAAA_5555;
    step();
    chk("w_setup_gnt", 32'(arb_gnt), 32'h1);
    chk("w_setup_pen", 32'(tim_penable), 32'd0);
    chk("w_setup_fields", {tim_pwrite, 15'd0, tim_pstrb, tim_paddr}, {1'b1, 15'd0, 4'hF, 12'h004});
    chk("w_setup_wdata", tim_pwdata, 32'h0000_00FF);
    m0_penable = 1'b1;
    step();
    chk("w_access_pen", 32'(tim_penable), 32'd1);
    chk("w_access_fields", {tim_pwrite, 15'd0, tim_pstrb, tim_paddr}, {1'b1, 15'd0, 4'hF, 12'h004});
    chk("w_access_wdata", tim_pwdata, 32'h0000_00FF);
    step();
    chk("w_resp_rdy", 32'(m0_pready), 32'd1);
    chk("w_resp_err", 32'(m0_pslverr), 32'd0);
    chk("w_resp_data0", m0_prdata, 32'h0);
    drv_m0(0, 0, 0, 12'h0, 32'h0, 4'h0);
    tim_pready = 1'b0;
    step();
    chk("w_idle_rdy", 32'(m0_pready), 32'd0);
    chk("w_idle_tim", {30'd0, tim_psel, tim_penable}, 32'h0);

    // Repeat collision: pointer now favours m1
    drv_m0(1, 0, 0, 12'h000, 32'h0, 4'h0);
    drv_m1(1, 0, 0, 12'h008, 32'h0, 4'h0);
    tim_pready = 1'b1; tim_prdata = 32'h3333_3333;
    step();
    chk("r_setup_gnt_m1", 32'(arb_gnt), 32'h2);
    chk("r_setup_addr", 32'(tim_paddr), 32'h008);
    m0_penable = 1'b1; m1_penable = 1'b1;
    step();
    step();
    chk("r_resp_m1_data", m1_prdata, 32'h3333_3333);
    chk("r_resp_m0_rdy", 32'(m0_pready), 32'd0);
    drv_m1(0, 0, 0, 12'h0, 32'h0, 4'h0);
    tim_prdata = 32'h4444_4444;
    step();
    step();
    chk("r2_setup_gnt_m0", 32'(arb_gnt), 32'h1);
    step();
    step();
    chk("r2_resp_m0_rdy", 32'(m0_pready), 32'd1);
    chk("r2_resp_m0_data", m0_prdata, 32'h4444_4444);
    drv_m0(0, 0, 0, 12'h0, 32'h0, 4'h0);
    tim_pready = 1'b0;
    step();

    // Timeout: timer never ready, abort after 16 ACCESS cycles
    drv_m0(1, 0, 0, 12'h00C, 32'h0, 4'h0);
    tim_prdata = 32'hBAD0_BAD0;
    step();
    m0_penable = 1'b1;
    for (int i = 0; i < 16; i++) begin
      step();
      chk($sformatf("to_wait_%0d", i), {30'd0, tim_penable, arb_timeout}, 32'h2);
    end
    step();
    chk("to_resp_rdy", 32'(m0_pready), 32'd1);
    chk("to_resp_err", 32'(m0_pslverr), 32'd1);
    chk("to_resp_data", m0_prdata, 32'h0);
    chk("to_pulse", 32'(arb_timeout), 32'd1);
    drv_m0(0, 0, 0, 12'h0, 32'h0, 4'h0);
    step();
    chk("to_pulse_end", 32'(arb_timeout), 32'd0);
    step();
    step();
    step();
    step();

    // Timer slave error on a read
    drv_m0(1, 0, 0, 12'h010, 32'h0, 4'h0);
    tim_pready = 1'b1; tim_pslverr = 1'b1; tim_prdata = 32'hDEAD_BEEF;
    step();
    m0_penable = 1'b1;
    step();
    step();
    chk("err_resp_err", 32'(m0_pslverr), 32'd1);
    chk("err_resp_data", m0_prdata, 32'hDEAD_BEEF);
    drv_m0(0, 0, 0, 12'h0, 32'h0, 4'h0);
    tim_pslverr = 1'b0; tim_prdata = 32'h5555_0000;
    step();

    // m1 abandons its transfer during ACCESS
    drv_m1(1, 0, 0, 12'h014, 32'h0, 4'h0);
    step();
    chk("ab_setup_gnt", 32'(arb_gnt), 32'h2);
    m1_penable = 1'b1;
    step();
    chk("ab_access_pen", 32'(tim_penable), 32'd1);
    drv_m1(0, 0, 0, 12'h0, 32'h0, 4'h0);
    step();
    chk("ab_resp_gnt", 32'(arb_gnt), 32'h2);
    chk("ab_resp_m1_rdy", 32'(m1_pready), 32'd0);
    chk("ab_resp_m1_data", m1_prdata, 32'h0);
    step();
    drv_m0(1, 0, 1, 12'h018, 32'h1234_5678, 4'h3);
    step();
    chk("ab_m0_gnt", 32'(arb_gnt), 32'h1);
    chk("ab_m0_wdata", tim_pwdata, 32'h1234_5678);
    m0_penable = 1'b1;
    step();
    step();
    chk("ab_m0_rdy", 32'(m0_pready), 32'd1);
    drv_m0(0, 0, 0, 12'h0, 32'h0, 4'h0);
    tim_pready = 1'b0;
    step();

    // Async reset during ACCESS; pointer favours m1 before it
    drv_m1(1, 0, 0, 12'h01C, 32'h0, 4'h0);
    step();
    m1_penable = 1'b1;
    step();
    chk("rs_access_pen", 32'(tim_penable), 32'd1);
    @(negedge sys_clk);
    sys_rst_n = 1'b0;
    #1;
    chk("rs_async_tim", {30'd0, tim_psel, tim_penable}, 32'h0);
    chk("rs_async_gnt", 32'(arb_gnt), 32'h0);
    step();
    @(negedge sys_clk);
    sys_rst_n = 1'b1;
    m1_penable = 1'b0;
    drv_m0(1, 0, 0, 12'h020, 32'h0, 4'h0);
    step();
    chk("rs_post_gnt_m0", 32'(arb_gnt), 32'h1);
    chk("rs_post_addr", 32'(tim_paddr), 32'h020);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
